// File: rtl/rand_pkg.sv
// rtl/rand_pkg.sv - shared constants and helpers for the range sampler
package rand_pkg;

  localparam int DEF_RANGE = 6;
  localparam int DEF_OUT_W = 3;
  localparam int DEF_DEPTH = 4;
  localparam int REJ_W     = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rand_range_sampler_sync_fifo.sv
// rtl/rand_range_sampler_sync_fifo.sv - first-word-fall-through FIFO with occupancy output
module sync_fifo
  import rand_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_valid,
  output logic [clog2(DEPTH):0]  o_level
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      w_level;
  logic             w_valid;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign w_level  = r_wr_ptr - r_rd_ptr;
  assign w_valid  = (w_level != '0);
  assign w_do_pop = i_pop && w_valid;

  assign o_level = w_level;
  assign o_valid = w_valid;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/rand_range_sampler.sv
// rtl/rand_range_sampler.sv - rejection-sampled uniform integers in [0, RANGE) from a random word stream
module rand_range_sampler
  import rand_pkg::*;
#(
  parameter int RANGE = DEF_RANGE,
  parameter int OUT_W = DEF_OUT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [31:0]            i_rnd_in,
  input  logic                   i_rnd_valid,
  output logic [OUT_W-1:0]       o_out_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [clog2(DEPTH):0]  o_level,
  output logic [REJ_W-1:0]       o_rej_count
);

  localparam int LW = clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [OUT_W:0] RANGE_L = (OUT_W + 1)'(RANGE);

  logic [OUT_W-1:0] w_cand;
  logic             w_accept;
  logic [LW-1:0]    w_occ;
  logic             w_take;
  logic             w_unused_bits;
  logic             r_stg_valid;
  logic [OUT_W-1:0] r_stg_data;
  logic [REJ_W-1:0] r_rej_count;

  assign w_cand        = i_rnd_in[OUT_W-1:0];
  assign w_unused_bits = ^i_rnd_in[31:OUT_W];
  assign w_accept      = ({1'b0, w_cand} < RANGE_L);

  // Staged value is counted against capacity; pops are not, so intake is conservative.
  assign w_occ  = o_level + LW'(r_stg_valid);
  assign w_take = i_rnd_valid && (w_occ < DEPTH_L);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stg_valid <= 1'b0;
      r_stg_data  <= '0;
      r_rej_count <= '0;
    end else begin
      r_stg_valid <= w_take && w_accept;
      if (w_take && w_accept) r_stg_data <= w_cand;
      if (w_take && !w_accept && (r_rej_count != '1))
        r_rej_count <= r_rej_count + REJ_W'(1);
    end
  end

  sync_fifo #(
    .WIDTH(OUT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (r_stg_valid),
    .i_push_data (r_stg_data),
    .i_pop       (i_out_ready),
    .o_head      (o_out_data),
    .o_valid     (o_out_valid),
    .o_level     (o_level)
  );

  assign o_rej_count = r_rej_count;

endmodule

// File: tb/tb_rand_range_sampler.sv
// tb/tb_rand_range_sampler.sv - self-checking bench for rand_range_sampler
module tb_rand_range_sampler;

  logic        clk;
  logic        rst_n;
  logic [31:0] rnd_in;
  logic        rnd_valid;
  logic [2:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic [15:0] rej_count;

  int n_cmp;
  int n_err;

  int m_q[$];
  bit m_stg_v;
  int m_stg_d;
  int m_rej;

  rand_range_sampler #(.RANGE(6), .OUT_W(3), .DEPTH(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rnd_in    (rnd_in),
    .i_rnd_valid (rnd_valid),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_level     (level),
    .o_rej_count (rej_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: values in [0,6) queue up in arrival order; capacity counts the staged value.
  task automatic cycle(input logic [31:0] rnd, input bit v, input bit rdy);
    int  c;
    bit  take;
    bit  acc;
    rnd_in    = rnd;
    rnd_valid = v;
    out_ready = rdy;
    @(posedge clk);
    c    = int'(rnd % 8);
    acc  = (c < 6);
    take = v && ((m_q.size() + int'(m_stg_v)) < 4);
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (m_stg_v) m_q.push_back(m_stg_d);
    m_stg_v = take && acc;
    if (take && acc) m_stg_d = c;
    if (take && !acc && m_rej < 65535) m_rej++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rnd_in = '0; rnd_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_q.delete(); m_stg_v = 0; m_stg_d = 0; m_rej = 0;
  endtask

  task automatic test_reset();
    rnd_in = '0; rnd_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (rej_count !== 16'd0) begin n_err++; $display("FAIL reset_rej got %0d want 0", rej_count); end
    do_reset();
  endtask

  task automatic test_single_accept();
    do_reset();
    cycle(32'h5, 1, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %0b want 0", out_valid); end
    cycle(32'h0, 0, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 3'd5) begin n_err++; $display("FAIL single_out got v=%0b d=%0d want v=1 d=5", out_valid, out_data); end
    n_cmp++; if (level !== 3'd1 || rej_count !== 16'd0) begin n_err++; $display("FAIL single_level got lvl=%0d rej=%0d want 1/0", level, rej_count); end
    cycle(32'h0, 0, 1);
    n_cmp++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_err++; $display("FAIL single_drain got v=%0b lvl=%0d want 0/0", out_valid, level); end
  endtask

  task automatic test_rejection();
    do_reset();
    cycle(32'h7, 1, 1);
    cycle(32'h6, 1, 1);
    cycle(32'h2, 1, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rej_no_early_out got %0b want 0", out_valid); end
    cycle(32'h0, 0, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 3'd2) begin n_err++; $display("FAIL rej_value got v=%0b d=%0d want v=1 d=2", out_valid, out_data); end
    n_cmp++; if (rej_count !== 16'd2) begin n_err++; $display("FAIL rej_count got %0d want 2", rej_count); end
    cycle(32'h0, 0, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rej_only_one got %0b want 0", out_valid); end
  endtask

  task automatic test_fill_backpressure();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(32'(i), 1, 0);
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fill_level got %0d want 4", level); end
    n_cmp++; if (rej_count !== 16'd0) begin n_err++; $display("FAIL fill_rej got %0d want 0", rej_count); end
    cycle(32'h1, 1, 0);
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fill_hold got %0d want 4", level); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 3'(i)) begin n_err++; $display("FAIL fill_order[%0d] got v=%0b d=%0d want v=1 d=%0d", i, out_valid, out_data, i); end
      cycle(32'h0, 0, 1);
    end
    n_cmp++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_err++; $display("FAIL fill_empty got v=%0b lvl=%0d want 0/0", out_valid, level); end
  endtask

  task automatic test_back_to_back();
    int sent[$];
    do_reset();
    for (int i = 0; i < 20; i++) begin
      int val;
      val = $urandom_range(0, 5);
      sent.push_back(val);
      cycle(32'($urandom) & 32'hFFFF_FFF8 | 32'(val), 1, 1);
      if (i >= 1) begin
        n_cmp++; if (level !== 3'd1 || out_valid !== 1'b1 || out_data !== 3'(sent[i-1])) begin
          n_err++; $display("FAIL b2b[%0d] got v=%0b d=%0d lvl=%0d want v=1 d=%0d lvl=1", i, out_valid, out_data, level, sent[i-1]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 100; i++) cycle(32'h7, 1, 1);
    n_cmp++; if (rej_count !== 16'd100) begin n_err++; $display("FAIL sat_partial got %0d want 100", rej_count); end
    for (int i = 100; i < 70000; i++) cycle(32'h7, 1, 1);
    n_cmp++; if (rej_count !== 16'hFFFF || int'(rej_count) !== m_rej) begin n_err++; $display("FAIL sat_final got %0d want 65535", rej_count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sat_no_out got %0b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(32'h7, 1, 0);
    for (int i = 0; i < 4; i++) cycle(32'(i), 1, 0);
    n_cmp++; if (level !== 3'd3 || rej_count !== 16'd1) begin n_err++; $display("FAIL arst_setup got lvl=%0d rej=%0d want 3/1", level, rej_count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || level !== 3'd0 || rej_count !== 16'd0) begin
      n_err++; $display("FAIL arst_clear got v=%0b lvl=%0d rej=%0d want 0/0/0", out_valid, level, rej_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_q.delete(); m_stg_v = 0; m_stg_d = 0; m_rej = 0;
    cycle(32'h4, 1, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_stale got %0b want 0", out_valid); end
    cycle(32'h0, 0, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 3'd4) begin n_err++; $display("FAIL arst_first got v=%0b d=%0d want v=1 d=4", out_valid, out_data); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      n_cmp++;
      if (out_valid !== (m_q.size() > 0) || int'(level) !== m_q.size() || int'(rej_count) !== m_rej ||
          (m_q.size() > 0 && int'(out_data) !== m_q[0])) begin
        n_err++;
        $display("FAIL random[%0d] got v=%0b d=%0d lvl=%0d rej=%0d want v=%0b d=%0d lvl=%0d rej=%0d",
                 i, out_valid, out_data, level, rej_count, m_q.size() > 0,
                 (m_q.size() > 0) ? m_q[0] : 0, m_q.size(), m_rej);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    rnd_in = '0; rnd_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_accept();
    test_rejection();
    test_fill_backpressure();
    test_back_to_back();
    test_async_reset();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rand_range_sampler.md
# rand_range_sampler

- Downstream consumer of the 32-bit xorshift generator.
- Converts the free-running random word stream into unbiased integers in [0, RANGE) by rejection sampling.
- Buffers the results in a small FIFO with a valid/ready output port.
- Feeds dice, LED-pattern and other game logic on the board.

## Interface
- RANGE, 6: number of output values; outputs span 0..RANGE-1; 2 ≤ RANGE ≤ 2^OUT_W.
- OUT_W, 3: output width; candidate bits taken from the random word.
- DEPTH, 4: FIFO depth; power of two, 2..16.
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- rnd_in  input  32  random word from the xorshift generator.
- rnd_valid  input  1  rnd_in holds a fresh word this cycle; tie high for a free-running generator.
- out_data  output  OUT_W  FIFO head value, in [0, RANGE).
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer takes out_data on an edge where out_valid && out_ready.
- level  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- rej_count  output  16  rejected candidates since reset; saturates at 0xFFFF.

## Operation
- Candidate: c = rnd_in[OUT_W-1:0], combinational.
- Acceptance test: accept = (c < RANGE), combinational.
- Credit: take = rnd_valid && (level + stg_valid < DEPTH), with level and stg_valid as registered values. Pops are not credited, so the check is conservative.
- Stage register (stg_data, stg_valid):
  - Each edge, stg_valid <= take && accept.
  - stg_data <= c when take && accept.
- Rejection: take && !accept increments rej_count (saturating). Nothing enters the stage.
- Dropped words: when !take, rnd_in is ignored and rej_count is unchanged. This counts neither as acceptance nor as rejection.
- FIFO push: stg_valid high at an edge writes stg_data. The credit rule guarantees a push never meets a full FIFO.
- FIFO pop: out_valid && out_ready at an edge removes the head.
- Simultaneous push and pop: level unchanged, both take effect.
- Pointers: wrap modulo DEPTH; level is derived from the pointer difference with an extra MSB.
- Output: first-word-fall-through; out_data shows the head combinationally from the storage array, registered pointer.
- out_data is don't-care while out_valid is low. The bench checks it only when out_valid is high.
- Ordering: accepted values leave in the same order as their rnd_in cycles.

## Timing
- Reset values (asserted asynchronously, held while reset is low):
  - stg_valid=0, level=0, out_valid=0, rej_count=0, both pointers 0.
  - FIFO storage is not reset.
- Latency: word accepted at edge N → stage at N → FIFO at N+1 → out_valid high in the cycle after edge N+1 (2 edges).
- Throughput: 1 value per cycle when every candidate is accepted and out_ready is held high.
- Full FIFO: level + stg_valid = DEPTH stops intake. Intake resumes on the first edge after a pop lowers the registered level.
- Reset mid-operation: any in-flight stage value and all FIFO contents are discarded. No output appears until 2 edges after reset deasserts and a word is accepted.

## Structure
- rand_pkg holds:
  - default RANGE/OUT_W/DEPTH constants;
  - the REJ_W=16 constant;
  - a clog2 function for the level width.
- Sub-module sync_fifo (parameters WIDTH, DEPTH), containing:
  - storage, pointers and level;
  - push/pop, FWFT head output and async active-low reset.
- rand_range_sampler itself holds:
  - the candidate/accept logic;
  - the credit check;
  - the stage register and the rejection counter.

## Test plan
All tests use RANGE=6, OUT_W=3, DEPTH=4.
- Single accept: after reset, one cycle of rnd_in=0x00000005, rnd_valid=1, out_ready=1 → out_valid high after the 2nd edge, out_data=5, level=1 for one cycle, rej_count=0.
- Rejection: rnd_in sequence 0x7, 0x6, 0x2 → rej_count=2; only value 2 appears, 2 edges after its input edge.
- Fill and back-pressure:
  - Stimulus: out_ready=0, rnd_in values 0,1,2,3,4,5 on consecutive cycles.
  - Response: level reaches 4; inputs 4 and 5 are dropped with rej_count still 0.
  - Then out_ready=1: outputs 0,1,2,3 in order, then out_valid=0.
- Simultaneous push/pop: steady accepted stream with out_ready=1 → level constant at 1; one output per cycle, matching input order.
- Saturation: drive rnd_in=0x7 for 70000 cycles → rej_count stops at 0xFFFF.
- Async reset mid-stream:
  - Stimulus: with level=3 and stg_valid=1, pull reset low between edges.
  - Response: out_valid=0, level=0 and rej_count=0 before the next edge; after release, the first output is the first post-reset accepted word.
